// File: rtl/vram_write_buffer.sv
// vram_write_buffer: CPU byte-write queue in front of the GPU VRAM port.
// Writes are accepted at any time. They are released to VRAM one per
// cycle, and only during vertical blanking, so scan-out never sees a
// mid-frame change.
module vram_write_buffer #(
  parameter int VRAM_ADDR_WIDTH = 14,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                         clk_12_5875,
  input  logic                         rst,
  input  logic                         cpu_wr_en,
  input  logic [VRAM_ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [7:0]                   cpu_data,
  output logic                         cpu_ready,
  input  logic                         vblank,
  output logic                         vram_we,
  output logic [VRAM_ADDR_WIDTH-1:0]   vram_address,
  output logic [7:0]                   vram_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = VRAM_ADDR_WIDTH + 8;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count_next;
  logic            push;
  logic            pop;
  logic            drop;

  // Fullness is judged on the registered count, so a pop in the same
  // cycle never makes room for a push while the queue is full.
  assign cpu_ready = (fifo_count < FULL_COUNT);
  assign push      = cpu_wr_en && cpu_ready;
  assign drop      = cpu_wr_en && !cpu_ready;
  assign pop       = (state == DRAIN) && vblank && (fifo_count != '0);

  // Occupancy after this edge. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  // Storage write port. It has no reset so it can map onto block RAM.
  always_ff @(posedge clk_12_5875) begin
    if (rst && push) begin
      mem[wr_ptr] <= {cpu_addr, cpu_data};
    end
  end

  // Pointers, count, sticky overflow, registered VRAM port and drain FSM.
  always_ff @(posedge clk_12_5875) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow     <= 1'b0;
      vram_we      <= 1'b0;
      vram_address <= '0;
      vram_data    <= '0;
      state        <= IDLE;
      busy         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr                    <= rd_ptr + 1'b1;
        {vram_address, vram_data} <= mem[rd_ptr];
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      fifo_count <= count_next;
      vram_we    <= pop;

      case (state)
        IDLE: begin
          if (vblank && (fifo_count != '0)) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          // Leave when blanking ends or when this cycle's pop empties the queue.
          if (!vblank || (count_next == '0)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_buffer.sv
// Testbench for vram_write_buffer. Directed stimulus pushes the expected VRAM
// writes into a scoreboard queue. A separate monitor pops from the queue and
// compares every vram_we cycle.
module tb_vram_write_buffer;
  localparam int AW    = 14;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_wr_en;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          cpu_ready;
  logic          vblank;
  logic          vram_we;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;
  logic [4:0]    fifo_count;
  logic          overflow;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int c0;
  int n;
  int n0;

  logic [AW+7:0] sb[$];
  int            we_cycles[$];
  logic [AW+7:0] exp_e;

  always #5 clk = ~clk;

  // Count edges so write timing can be checked relative to stimulus.
  always @(posedge clk) cyc <= cyc + 1;

  vram_write_buffer #(.VRAM_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_12_5875 (clk),
    .rst         (rst),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ready   (cpu_ready),
    .vblank      (vblank),
    .vram_we     (vram_we),
    .vram_address(vram_address),
    .vram_data   (vram_data),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // Monitor: every VRAM write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (vram_we === 1'b1) begin
        we_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   vram_address, vram_data);
        end else begin
          exp_e = sb.pop_front();
          check("vram_write", 32'({vram_address, vram_data}), 32'(exp_e));
        end
      end
    end
  end

  // Inputs are driven and the bench samples just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d, input bit accept);
    cpu_wr_en = 1'b1;
    cpu_addr  = a;
    cpu_data  = d;
    if (accept) sb.push_back({a, d});
    tick();
    cpu_wr_en = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int k;
    k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Hold reset for two edges while a CPU write is requested.
    rst       = 1'b0;
    cpu_wr_en = 1'b1;
    cpu_addr  = 14'h1234;
    cpu_data  = 8'h55;
    vblank    = 1'b0;
    tick();
    tick();
    check("rst_vram_we", 32'(vram_we), 32'd0);
    check("rst_vram_address", 32'(vram_address), 32'd0);
    check("rst_vram_data", 32'(vram_data), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst       = 1'b1;
    cpu_wr_en = 1'b0;
    tick();
    check("post_rst_count", 32'(fifo_count), 32'd0);

    // Ordering: three writes queued outside vblank, then drained.
    push(14'h0100, 8'hAA, 1'b1);
    push(14'h0101, 8'hBB, 1'b1);
    push(14'h3FFF, 8'hCC, 1'b1);
    check("order_count", 32'(fifo_count), 32'd3);
    check("order_no_we_before_vblank", 32'(we_cycles.size()), 32'd0);
    c0     = cyc;
    vblank = 1'b1;
    repeat (6) tick();
    check("order_write_total", 32'(we_cycles.size()), 32'd3);
    for (int i = 0; i < we_cycles.size(); i++)
      check("order_write_cycle", 32'(we_cycles[i]), 32'(c0 + 2 + i));
    check("order_busy_after", 32'(busy), 32'd0);
    check("order_count_after", 32'(fifo_count), 32'd0);
    vblank = 1'b0;
    we_cycles.delete();
    tick();

    // Full: 16 accepted, the 17th is dropped and flags overflow.
    for (int i = 0; i < 16; i++)
      push(14'(14'h0200 + i), 8'(8'h10 + i), 1'b1);
    check("full_ready", 32'(cpu_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_no_overflow_yet", 32'(overflow), 32'd0);
    push(14'h0300, 8'hEE, 1'b0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_count_after_drop", 32'(fifo_count), 32'd16);
    vblank = 1'b1;
    wait_empty("full_drain_empty", 40);
    repeat (2) tick();
    check("full_drain_writes", 32'(we_cycles.size()), 32'd16);
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_overflow_sticky", 32'(overflow), 32'd1);
    vblank = 1'b0;
    we_cycles.delete();
    tick();

    // Vblank cut: ten queued entries and five vblank cycles give four writes.
    for (int i = 0; i < 10; i++)
      push(14'(14'h0400 + i), 8'(8'h40 + i), 1'b1);
    c0     = cyc;
    vblank = 1'b1;
    repeat (5) tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("cut_writes", 32'(we_cycles.size()), 32'd4);
    if (we_cycles.size() > 0)
      check("cut_last_write_cycle", 32'(we_cycles[we_cycles.size() - 1]), 32'(c0 + 5));
    check("cut_count", 32'(fifo_count), 32'd6);
    check("cut_busy", 32'(busy), 32'd0);
    vblank = 1'b1;
    wait_empty("cut_rest_empty", 20);
    tick();
    check("cut_total_writes", 32'(we_cycles.size()), 32'd10);
    vblank = 1'b0;
    we_cycles.delete();
    tick();

    // Concurrent push/pop while draining. The read pointer wraps past 15.
    for (int i = 0; i < 4; i++)
      push(14'(14'h0500 + i), 8'(8'h50 + i), 1'b1);
    vblank = 1'b1;
    tick();
    check("conc_busy", 32'(busy), 32'd1);
    check("conc_count_start", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 12; i++) begin
      push(14'(14'h0600 + i), 8'(8'h60 + i), 1'b1);
      check("conc_count", 32'(fifo_count), 32'd4);
    end
    wait_empty("conc_empty", 20);
    tick();
    check("conc_count_end", 32'(fifo_count), 32'd0);
    vblank = 1'b0;
    tick();

    // Reset in mid-drain discards everything still queued.
    for (int i = 0; i < 8; i++)
      push(14'(14'h0700 + i), 8'(8'h70 + i), 1'b1);
    vblank = 1'b1;
    n = 0;
    while (vram_we !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("mid_drain_started", 32'(vram_we), 32'd1);
    rst = 1'b0;
    tick();
    sb.delete();
    check("mid_rst_vram_we", 32'(vram_we), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_ready", 32'(cpu_ready), 32'd1);
    check("mid_rst_address", 32'(vram_address), 32'd0);
    rst = 1'b1;
    n0  = we_cycles.size();
    repeat (10) tick();
    check("mid_rst_no_writes", 32'(we_cycles.size()), 32'(n0));
    check("mid_rst_count_after", 32'(fifo_count), 32'd0);
    vblank = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_write_buffer.md
# vram_write_buffer

CPU-side write buffer that sits directly upstream of `gpu_m`'s VRAM data/address inputs. It accepts byte writes from the CPU bus at any time and queues them in a small FIFO. It drains them to VRAM one per cycle only while the GPU timing generator reports vertical blanking. This keeps the pixel pipeline from seeing VRAM contents change mid-frame.

## Interface
- `VRAM_ADDR_WIDTH`, default 14: width of the VRAM byte address; must equal the GPU's `VRAM_ADDR_WIDTH`.
- `FIFO_DEPTH`, default 16: entries; must be a power of two, ≥ 2.
- `clk_12_5875`  in  1: GPU pixel clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-low reset (low = reset).
- `cpu_wr_en`  in  1: CPU write request for this cycle.
- `cpu_addr`  in  VRAM_ADDR_WIDTH: target VRAM address.
- `cpu_data`  in  8: byte to write.
- `cpu_ready`  out  1: FIFO can accept a write this cycle.
- `vblank`  in  1: high during vertical blanking, from the timing generator.
- `vram_we`  out  1: write strobe to VRAM, one cycle per entry.
- `vram_address`  out  VRAM_ADDR_WIDTH: write address, valid when `vram_we`=1.
- `vram_data`  out  8: write data, valid when `vram_we`=1.
- `fifo_count`  out  log2(FIFO_DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky; set when a write was dropped.
- `busy`  out  1: high while in DRAIN state.

## Operation
- Storage is a circular FIFO of {addr, data} entries with read and write pointers of log2(FIFO_DEPTH) bits. Pointers wrap modulo FIFO_DEPTH.
- `cpu_ready` is combinational: high when `fifo_count` < FIFO_DEPTH.
- Push: when `cpu_wr_en` && `cpu_ready`, the entry is written at the write pointer and the write pointer advances.
- Dropped write: when `cpu_wr_en` && !`cpu_ready`, nothing is stored and `overflow` is set on the next edge. `overflow` clears only on reset.
- FSM states:
  - IDLE: go to DRAIN when `vblank` && `fifo_count` ≠ 0.
  - DRAIN: pop one entry per cycle while `vblank` && `fifo_count` ≠ 0.
  - DRAIN → IDLE when `vblank`=0, or when the pop in this cycle empties the FIFO.
- Pop: the entry at the read pointer is registered onto `vram_address`/`vram_data` with `vram_we`=1 on the next edge, and the read pointer advances.
- When no pop occurs, `vram_we`=0 on the next edge. Address and data hold their last values.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged.
  - Full-ness is judged on the pre-edge count, so a push while full is dropped even if a pop happens in the same cycle.
- Ordering is strictly FIFO. Repeated writes to the same address are all emitted, in order; no coalescing.
- `busy` = (state == DRAIN).

## Timing
- Reset (`rst`=0 at an edge) drives all of the following on that edge:
  - `vram_we`=0, `vram_address`=0, `vram_data`=0.
  - `fifo_count`=0, both pointers 0, `overflow`=0, state IDLE, `busy`=0.
  - `cpu_ready`=1.
  - Reset in mid-drain discards all queued entries; no further `vram_we`.
- Push latency: a write accepted at edge N is reflected in `fifo_count` after edge N.
- Drain latency:
  - `vblank` high and FIFO non-empty in cycle N → the FSM enters DRAIN at edge N+1.
  - The first pop happens in cycle N+1, so `vram_we` first goes high after edge N+2.
  - Throughput is then one write per cycle.
- A write pushed into an empty FIFO during DRAIN is drained in the same vblank. The FSM re-enters DRAIN from IDLE if it had left.
- `vblank` falling in cycle M: no pop in cycle M. A pop from cycle M−1 still produces `vram_we` after edge M; this one-cycle tail is permitted by the GPU.
- `busy` and `vram_we` are registered. `cpu_ready` follows `fifo_count` the same cycle.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `cpu_wr_en`=1 → all outputs at reset values, `fifo_count`=0, `cpu_ready`=1.
- Ordering, no pops:
  - Stimulus: with `vblank`=0, push (0x0100,0xAA), (0x0101,0xBB), (0x3FFF,0xCC).
  - Expected before vblank: `fifo_count`=3 and no `vram_we`.
  - Expected after raising `vblank`: `vram_we` high for exactly 3 consecutive cycles starting 2 cycles after `vblank` rises, in that order; then `busy`=0.
- Full/overflow: push 17 writes with `vblank`=0 (FIFO_DEPTH=16) → `cpu_ready`=0 after the 16th, 17th dropped, `overflow`=1, `fifo_count`=16. A later drain emits exactly 16 writes.
- Vblank cut:
  - Stimulus: queue 10 entries, hold `vblank` high 5 cycles.
  - Expected: exactly 4 writes, the last one after the falling edge; `fifo_count`=6 and `busy`=0.
  - Expected on the next vblank: the remaining 6 entries drain in order.
- Concurrent push/pop: push one entry per cycle during DRAIN with 4 entries queued → `fifo_count` stays 4 while both occur; a pointer wrap past index 15 preserves order.
- Reset mid-drain: assert `rst`=0 while `vram_we` is toggling → `vram_we`=0 after that edge, `fifo_count`=0, and no writes on the next vblank.
